// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bit positions and controller state encoding
// for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_LSL  = 4'b0000;
    localparam logic [3:0] OP_LSR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_CBZ  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, fixed WIDTH
// iterations regardless of operand values, low WIDTH product bits only.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // The start edge already retires bit 0, so done rises after exactly WIDTH bits.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done     = busy_q && (cnt_q == LAST);
        if (start) begin
            acc_d    = b[0] ? a : '0;
            mcand_d  = a << 1;
            mplier_d = b >> 1;
            cnt_d    = CW'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith ops,
// WIDTH-cycle iterative multiply, registered result with {N,Z,C,V} flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_illegal
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d, out_illegal_q, out_illegal_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [3:0]       out_flags_q, out_flags_d;

    logic             mul_start, mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   wide;
    logic             alu_c, alu_v, alu_ill;
    logic [SHW-1:0]   sh;
    logic             is_mul, accept;

    function automatic logic [3:0] make_flags(logic [WIDTH-1:0] res, logic c, logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = res[WIDTH-1];
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign sh     = in_b[SHW-1:0];
    assign is_mul = (in_op == OP_MUL) && (MUL_EN != 0);

    // Single-cycle datapath; the extra bit of wide carries carry/borrow/shifted-out bit.
    always_comb begin
        alu_res = '0;
        wide    = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (in_op)
            OP_ADD: begin
                wide    = {1'b0, in_a} + {1'b0, in_b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                wide    = {1'b0, in_a} - {1'b0, in_b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = ~wide[WIDTH];
                alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_LSL: begin
                wide    = {1'b0, in_a} << sh;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_LSR: begin
                wide    = {in_a, 1'b0} >> sh;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_NAND: alu_res = ~(in_a & in_b);
            OP_MOV:  alu_res = in_a;
            OP_CBZ:  alu_res = {{(WIDTH-1){1'b0}}, (in_a == '0)};
            OP_MUL:  alu_ill = (MUL_EN == 0);
            default: alu_ill = 1'b1;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE) && !mul_busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // The output register is only ever written when it is empty or being drained this edge.
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q && !out_ready;
        out_result_d  = out_result_q;
        out_flags_d   = out_flags_q;
        out_illegal_d = out_illegal_q;
        mul_start     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end else if (accept) begin
                    out_valid_d   = 1'b1;
                    out_result_d  = alu_ill ? '0 : alu_res;
                    out_flags_d   = alu_ill ? 4'b0000 : make_flags(alu_res, alu_c, alu_v);
                    out_illegal_d = alu_ill;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    out_valid_d   = 1'b1;
                    out_result_d  = mul_product;
                    out_flags_d   = make_flags(mul_product, 1'b0, 1'b0);
                    out_illegal_d = 1'b0;
                    state_d       = out_ready ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_flags_q   <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_flags_q   <= out_flags_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .a       (in_a),
                .b       (in_b),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_flags   = out_flags_q;
    assign out_illegal = out_illegal_q;

endmodule
